kfps2kb_receive_controller: RTL and testbench
=============================================

// Module: kfps2kb_receive_controller
// PURPOSE
// - Sequences the PS/2 keyboard receive shift register and buffers its bytes for the XT keyboard port.
// - Queues received scan bytes in a FIFO and raises irq while bytes are waiting.
// - Drives the PS/2 clock-inhibit line when disabled, when the FIFO is full, or after a frame error.
// - Pulses the receiver reset after an error so the shift register restarts cleanly.
// PARAMETERS
// - DEPTH          16      FIFO entries; power of two, >= 2
// - LEVEL_WIDTH    5       width of buffer_level; must equal log2(DEPTH)+1
// - INHIBIT_TICKS  16'd100 minimum inhibit time, in peripheral_clock rising edges
// PORTS
// - clock                  in   1  system clock; the only clock in this block
// - reset_n                in   1  reset; synchronous, active-low
// - peripheral_clock       in   1  slow timebase; synchronised with 2 flops, one rising-edge tick per edge
// - enable                 in   1  1 = keyboard interface enabled
// - rx_data                in   8  byte from the shift register
// - rx_received            in   1  1-cycle pulse: rx_data valid, parity good
// - rx_error               in   1  1-cycle pulse: parity, stop-bit or timeout error
// - read_strobe            in   1  1-cycle pulse: pop the FIFO head
// - clear_buffer           in   1  flush the FIFO and clear overrun
// - data_out               out  8  FIFO head; meaningful only while data_valid=1
// - data_valid             out  1  FIFO not empty
// - irq                    out  1  data_valid & enable
// - buffer_level           out  LEVEL_WIDTH  entry count, 0..DEPTH
// - overrun                out  1  sticky: a byte arrived while the FIFO was full
// - keyboard_clock_inhibit out  1  1 = hold the PS/2 clock low
// - receiver_reset         out  1  1 = reset the shift register
// BEHAVIOUR
// - Reset, while reset_n=0 at a clock edge:
//   - state=INHIBIT; FIFO empty; tick counter 0; overrun 0.
//   - keyboard_clock_inhibit=1; receiver_reset=1.
//   - data_valid, irq and buffer_level = 0.
//   - A reset mid-frame or mid-inhibit discards everything.
// - FSM states: INHIBIT, RUN, ERROR.
// - INHIBIT:
//   - Inhibit asserted.
//   - Tick counter counts peripheral ticks and saturates at INHIBIT_TICKS; it is cleared on entry.
//   - Goes to RUN when counter>=INHIBIT_TICKS & enable & !full.
// - RUN:
//   - Inhibit released.
//   - Priority: rx_error -> ERROR; else !enable, or full after this cycle's push -> INHIBIT.
// - ERROR:
//   - Lasts exactly 1 cycle, with receiver_reset=1 and inhibit=1; then goes to INHIBIT.
// - Output timing:
//   - receiver_reset is registered: 1 in ERROR and in the first cycle after reset, else 0.
//   - keyboard_clock_inhibit is registered and follows the state.
// - Push (any state):
//   - On rx_received & !full, rx_data is written at the tail.
//   - The byte is visible on data_out/data_valid in the cycle after the pulse (1-cycle latency).
// - Push while full:
//   - The byte is dropped, FIFO unchanged, overrun<=1.
//   - The FSM is already in INHIBIT.
// - Pop:
//   - read_strobe & data_valid advances the head.
//   - read_strobe while empty is ignored and causes no underflow.
// - Simultaneous push and pop:
//   - Non-empty, not full: both happen, level unchanged.
//   - Full: pop happens and push is accepted; no overrun.
//   - Empty: pop ignored, push accepted.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; level is tracked separately, 0..DEPTH.
// - clear_buffer:
//   - Empties the FIFO and clears overrun.
//   - Overrides push and pop in the same cycle; the FSM is unaffected.
// - data_out shows the memory at the head pointer; its value when empty is don't-care.
// CONFIGURATION
// - KFPS2KB_OVERRUN_CODE_EN defined:
//   - A push while full overwrites the newest entry (tail-1) with 8'hFF, the XT overrun code.
//   - overrun is still set.
//   - Simultaneous push+pop while full still follows the no-overrun rule.
// - Not defined: the byte is dropped and FIFO contents are untouched.
// TESTING
// - Reset, then enable=1: inhibit=1 for 100 ticks, then 0; receiver_reset=1 only in the first cycle after reset.
// - Push 8'h1C: next cycle data_out=8'h1C, data_valid=1, irq=1, level=1; read_strobe -> level=0, irq=0.
// - 16 pushes without reads: at the 16th push inhibit goes 1 next cycle; a 17th push sets overrun=1 and
//   level stays 16 (with the macro, entry 15 reads 8'hFF); one pop + 100 ticks -> inhibit 0.
// - rx_error in RUN: receiver_reset=1 for exactly 1 cycle, inhibit=1 for >=100 ticks, then RUN.
// - Full FIFO plus read_strobe and rx_received in the same cycle: level stays 16, overrun stays 0,
//   new byte at the tail; clear_buffer together with a push -> level 0, overrun 0.
// - Enable dropped mid-RUN -> INHIBIT; reset_n low mid-inhibit -> tick counter restarts, FIFO empty.

Source files
------------

// File: rtl/kfps2kb_receive_controller.sv
// PS/2 keyboard receive sequencer and scan-byte FIFO for the XT port.
// Ports: clock, reset_n, peripheral_clock, enable, rx_*, read_strobe,
//   clear_buffer in; data_out, data_valid, irq, buffer_level, overrun,
//   keyboard_clock_inhibit, receiver_reset out.
// Build option: KFPS2KB_OVERRUN_CODE_EN replaces the newest entry with
//   8'hFF when a byte arrives while the FIFO is full.
module kfps2kb_receive_controller #(
  parameter int          DEPTH         = 16,
  parameter int          LEVEL_WIDTH   = 5,
  parameter logic [15:0] INHIBIT_TICKS = 16'd100
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   peripheral_clock,
  input  logic                   enable,
  input  logic [7:0]             rx_data,
  input  logic                   rx_received,
  input  logic                   rx_error,
  input  logic                   read_strobe,
  input  logic                   clear_buffer,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  output logic                   irq,
  output logic [LEVEL_WIDTH-1:0] buffer_level,
  output logic                   overrun,
  output logic                   keyboard_clock_inhibit,
  output logic                   receiver_reset
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_INHIBIT,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t state;

  logic [2:0]             pclk_sync;
  logic                   tick;
  logic [15:0]            tick_count;
  logic [7:0]             mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LEVEL_WIDTH-1:0] level;
  logic [LEVEL_WIDTH-1:0] level_next;
  logic                   full;
  logic                   full_next;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Two sync flops plus one history flop for rising-edge detect.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pclk_sync <= '0;
    end else begin
      pclk_sync <= {pclk_sync[1:0], peripheral_clock};
    end
  end

  assign tick = pclk_sync[1] & ~pclk_sync[2];

  assign full       = level == LEVEL_WIDTH'(DEPTH);
  assign data_valid = level != '0;
  assign pop        = read_strobe & data_valid;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push       = rx_received & (~full | pop);
  assign drop       = rx_received & full & ~pop;

  always_comb begin
    level_next = level;
    if (clear_buffer) begin
      level_next = '0;
    end else if (push & ~pop) begin
      level_next = level + 1'b1;
    end else if (pop & ~push) begin
      level_next = level - 1'b1;
    end
  end

  assign full_next = level_next == LEVEL_WIDTH'(DEPTH);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      level <= level_next;
      if (clear_buffer) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        overrun <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (drop) overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push & ~clear_buffer) begin
      mem[wr_ptr] <= rx_data;
    end
`ifdef KFPS2KB_OVERRUN_CODE_EN
    else if (drop & ~clear_buffer) begin
      mem[PTR_W'(wr_ptr - 1'b1)] <= 8'hFF;
    end
`endif
  end

  assign data_out     = mem[rd_ptr];
  assign buffer_level = level;
  assign irq          = data_valid & enable;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                  <= ST_INHIBIT;
      tick_count             <= '0;
      keyboard_clock_inhibit <= 1'b1;
      receiver_reset         <= 1'b1;
    end else begin
      receiver_reset <= 1'b0;
      unique case (state)
        ST_INHIBIT: begin
          keyboard_clock_inhibit <= 1'b1;
          if (tick_count >= INHIBIT_TICKS && enable && !full) begin
            state                  <= ST_RUN;
            keyboard_clock_inhibit <= 1'b0;
          end else if (tick && tick_count < INHIBIT_TICKS) begin
            tick_count <= tick_count + 1'b1;
          end
        end
        ST_RUN: begin
          if (rx_error) begin
            state                  <= ST_ERROR;
            receiver_reset         <= 1'b1;
            keyboard_clock_inhibit <= 1'b1;
          end else if (!enable || full_next) begin
            state                  <= ST_INHIBIT;
            tick_count             <= '0;
            keyboard_clock_inhibit <= 1'b1;
          end else begin
            keyboard_clock_inhibit <= 1'b0;
          end
        end
        ST_ERROR: begin
          state                  <= ST_INHIBIT;
          tick_count             <= '0;
          keyboard_clock_inhibit <= 1'b1;
        end
        default: begin
          state                  <= ST_INHIBIT;
          tick_count             <= '0;
          keyboard_clock_inhibit <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kfps2kb_receive_controller.sv
// Bench for kfps2kb_receive_controller: directed pins plus random traffic
// against a queue-based model of the FIFO and inhibit rules.
module tb_kfps2kb_receive_controller;
  localparam int DEPTH = 16;
  localparam int TICKS = 100;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       peripheral_clock = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_received = 1'b0;
  logic       rx_error = 1'b0;
  logic       read_strobe = 1'b0;
  logic       clear_buffer = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       irq;
  logic [4:0] buffer_level;
  logic       overrun;
  logic       keyboard_clock_inhibit;
  logic       receiver_reset;

  kfps2kb_receive_controller dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .peripheral_clock       (peripheral_clock),
    .enable                 (enable),
    .rx_data                (rx_data),
    .rx_received            (rx_received),
    .rx_error               (rx_error),
    .read_strobe            (read_strobe),
    .clear_buffer           (clear_buffer),
    .data_out               (data_out),
    .data_valid             (data_valid),
    .irq                    (irq),
    .buffer_level           (buffer_level),
    .overrun                (overrun),
    .keyboard_clock_inhibit (keyboard_clock_inhibit),
    .receiver_reset         (receiver_reset)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Peripheral timebase: strict toggle in directed phase, random later.
  bit pc_rand = 0;
  always @(negedge clock) begin
    if (pc_rand) peripheral_clock = 1'($urandom_range(0, 1));
    else         peripheral_clock = ~peripheral_clock;
  end

  // Reference model: FIFO is a queue; link is "running" or not.
  logic [7:0] q[$];
  bit         m_ov;
  bit         m_run;
  bit         m_err;
  int         m_ticks;
  bit [2:0]   m_pc;
  bit         m_rr;
  bit         m_ok = 0;

  always @(posedge clock) begin
    bit tick;
    bit full0;
    bit pop;
    if (!reset_n) begin
      q.delete();
      m_ov = 0; m_run = 0; m_err = 0;
      m_ticks = 0; m_pc = '0; m_rr = 1; m_ok = 1;
    end else begin
      // Tick when the sample from two edges ago is a fresh rise.
      tick = m_pc[1] && !m_pc[2];
      m_pc = {m_pc[1:0], peripheral_clock};
      full0 = q.size() == DEPTH;
      if (clear_buffer) begin
        q.delete();
        m_ov = 0;
      end else begin
        pop = read_strobe && q.size() > 0;
        if (pop) void'(q.pop_front());
        if (rx_received) begin
          if (!full0 || pop) q.push_back(rx_data);
          else begin
            m_ov = 1;
`ifdef KFPS2KB_OVERRUN_CODE_EN
            q[q.size()-1] = 8'hFF;
`endif
          end
        end
      end
      m_rr = 0;
      if (m_err) begin
        m_err = 0; m_ticks = 0;
      end else if (m_run) begin
        if (rx_error) begin
          m_run = 0; m_err = 1; m_rr = 1;
        end else if (!enable || q.size() == DEPTH) begin
          m_run = 0; m_ticks = 0;
        end
      end else if (m_ticks >= TICKS && enable && !full0) begin
        m_run = 1;
      end else if (tick && m_ticks < TICKS) begin
        m_ticks++;
      end
    end
    #1;
    if (m_ok) begin
      chk("m_inhibit", keyboard_clock_inhibit, !m_run);
      chk("m_rx_reset", receiver_reset, m_rr);
      chk("m_level", buffer_level, q.size());
      chk("m_valid", data_valid, q.size() != 0);
      chk("m_irq", irq, (q.size() != 0) && enable);
      chk("m_overrun", overrun, m_ov);
      if (q.size() != 0) chk("m_data", data_out, q[0]);
    end
  end

  task automatic drv(bit rcv, logic [7:0] d, bit err, bit rd, bit clr);
    rx_received  = rcv;
    rx_data      = d;
    rx_error     = err;
    read_strobe  = rd;
    clear_buffer = clr;
    @(negedge clock);
    rx_received  = 0;
    rx_error     = 0;
    read_strobe  = 0;
    clear_buffer = 0;
  endtask

  task automatic wait_run(string name, output int n);
    n = 0;
    while (keyboard_clock_inhibit && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(name, keyboard_clock_inhibit, 1'b0);
  endtask

  int n;
  int push_p;
  int read_p;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_inhibit", keyboard_clock_inhibit, 1'b1);
    chk("rst_rx_reset", receiver_reset, 1'b1);
    chk("rst_level", buffer_level, 5'd0);
    chk("rst_irq", irq, 1'b0);
    reset_n = 1;
    enable = 1;
    @(negedge clock);
    chk("rx_reset_first", receiver_reset, 1'b0);
    chk("inhibit_held", keyboard_clock_inhibit, 1'b1);
    wait_run("release1", n);
    chk("hold_len", (n >= 190 && n <= 215), 1'b1);

    drv(1, 8'h1C, 0, 0, 0);
    chk("push_data", data_out, 8'h1C);
    chk("push_valid", data_valid, 1'b1);
    chk("push_irq", irq, 1'b1);
    chk("push_level", buffer_level, 5'd1);
    drv(0, 8'h00, 0, 1, 0);
    chk("pop_level", buffer_level, 5'd0);
    chk("pop_irq", irq, 1'b0);

    for (int i = 0; i < DEPTH; i++) drv(1, 8'h30 + 8'(i), 0, 0, 0);
    chk("full_level", buffer_level, 5'd16);
    chk("full_inhibit", keyboard_clock_inhibit, 1'b1);
    drv(1, 8'h99, 0, 1, 0);
    chk("pp_level", buffer_level, 5'd16);
    chk("pp_overrun", overrun, 1'b0);
    chk("pp_head", data_out, 8'h31);
    drv(1, 8'hAA, 0, 0, 0);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_level", buffer_level, 5'd16);
    drv(1, 8'h55, 0, 0, 1);
    chk("clr_level", buffer_level, 5'd0);
    chk("clr_overrun", overrun, 1'b0);
    wait_run("release2", n);

    drv(0, 8'h00, 1, 0, 0);
    chk("err_rx_reset", receiver_reset, 1'b1);
    chk("err_inhibit", keyboard_clock_inhibit, 1'b1);
    @(negedge clock);
    chk("err_one_cycle", receiver_reset, 1'b0);
    chk("err_inhibit2", keyboard_clock_inhibit, 1'b1);
    wait_run("release3", n);
    chk("err_hold_len", n >= 190, 1'b1);

    enable = 0;
    @(negedge clock);
    chk("dis_inhibit", keyboard_clock_inhibit, 1'b1);
    enable = 1;
    drv(1, 8'h77, 0, 0, 0);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    chk("mid_rst_level", buffer_level, 5'd0);
    chk("mid_rst_inhibit", keyboard_clock_inhibit, 1'b1);

    pc_rand = 1;
    push_p = 30;
    read_p = 20;
    for (int c = 0; c < 6000; c++) begin
      if (c % 250 == 0) begin
        push_p = $urandom_range(10, 70);
        read_p = $urandom_range(0, 50);
      end
      reset_n      = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rx_received  = ($urandom_range(0, 99) < push_p);
      rx_data      = 8'($urandom);
      rx_error     = ($urandom_range(0, 149) == 0);
      read_strobe  = ($urandom_range(0, 99) < read_p);
      clear_buffer = ($urandom_range(0, 199) == 0);
      @(negedge clock);
    end
    reset_n = 1;
    rx_received = 0; rx_error = 0;
    read_strobe = 0; clear_buffer = 0;
    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
